// File: rtl/red_pkg.sv
// Shared constants and state encoding for the RED split/reduce blocks.
package red_pkg;

  localparam logic signed [16:0] RED_MIN  = -17'sd512;
  localparam logic signed [16:0] RED_MAX  = 17'sd508;
  localparam logic signed [16:0] LANE_MIN = -17'sd128;
  localparam logic signed [16:0] LANE_MAX = 17'sd127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/red_16bit.sv
// RED reduction: sum of the four signed byte lanes of {a, b}, sign-extended to 16 bits.
module red_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  // Sign-extend each lane and add.
  always_comb begin
    result = {{8{a[15]}}, a[15:8]} + {{8{a[7]}}, a[7:0]}
           + {{8{b[15]}}, b[15:8]} + {{8{b[7]}}, b[7:0]};
  end

endmodule

// File: rtl/red_split_16bit.sv
// Greedy multi-cycle split of a signed sum S into four saturating byte lanes.
// Optional self-check against red_16bit when RED_SPLIT_CHECK_EN is defined.
module red_split_16bit
  import red_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] s_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] A_out,
  output logic [15:0] B_out,
  output logic        ovf,
  output logic        chk_err
);

  state_t             state_r;
  state_t             state_s;
  logic signed [16:0] rem_r;
  logic signed [16:0] s_ext_s;
  logic [1:0]         idx_r;
  logic [31:0]        lanes_r;
  logic [31:0]        lanes_next_s;
  logic [7:0]         lane_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               ovf_r;
  logic               chk_err_r;
  logic               chk_s;

  function automatic logic [7:0] sat8(input logic signed [16:0] v);
    if (v > LANE_MAX) begin
      return 8'h7F;
    end else if (v < LANE_MIN) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

  // Current lane value and the lane vector as it will look after this SPLIT cycle.
  always_comb begin
    s_ext_s      = $signed({s_in[15], s_in});
    lane_s       = sat8(rem_r);
    lanes_next_s = lanes_r;
    case (idx_r)
      2'd0:    lanes_next_s[31:24] = lane_s;
      2'd1:    lanes_next_s[23:16] = lane_s;
      2'd2:    lanes_next_s[15:8]  = lane_s;
      2'd3:    lanes_next_s[7:0]   = lane_s;
      default: lanes_next_s        = lanes_r;
    endcase
  end

`ifdef RED_SPLIT_CHECK_EN
  logic [15:0] s_r;
  logic [15:0] red_sum_s;

  // The reducer sees the final lanes on the DONE entry edge.
  red_16bit u_red (
    .a      (lanes_next_s[31:16]),
    .b      (lanes_next_s[15:0]),
    .result (red_sum_s)
  );

  // Hold the accepted S for comparison against the reduced lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r <= 16'd0;
    end else if ((state_r == IDLE) && in_valid) begin
      s_r <= s_in;
    end
  end

  // Mismatch only matters when the split was supposed to be exact.
  always_comb begin
    chk_s = ~ovf_r & (red_sum_s != s_r);
  end
`else
  // Self-check absent: never flag.
  always_comb begin
    chk_s = 1'b0;
  end
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = in_valid ? SPLIT : IDLE;
      SPLIT:   state_s = (idx_r == 2'd3) ? DONE : SPLIT;
      DONE:    state_s = out_ready ? IDLE : DONE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rem_r       <= 17'sd0;
      idx_r       <= 2'd0;
      lanes_r     <= 32'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      chk_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rem_r     <= s_ext_s;
            idx_r     <= 2'd0;
            lanes_r   <= 32'd0;
            ovf_r     <= (s_ext_s < RED_MIN) | (s_ext_s > RED_MAX);
            chk_err_r <= 1'b0;
          end
        end
        SPLIT: begin
          lanes_r   <= lanes_next_s;
          rem_r     <= rem_r - $signed({{9{lane_s[7]}}, lane_s});
          idx_r     <= idx_r + 2'd1;
          chk_err_r <= (idx_r == 2'd3) ? chk_s : 1'b0;
        end
        DONE: begin
          if (out_ready) begin
            chk_err_r <= 1'b0;
          end
        end
        default: begin
          chk_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign A_out     = lanes_r[31:16];
  assign B_out     = lanes_r[15:0];
  assign ovf       = ovf_r;
  assign chk_err   = chk_err_r;

endmodule

// File: tb/tb_red_split_16bit.sv
// Scoreboard bench for red_split_16bit: driver pushes expected results, negedge monitor checks.
module tb_red_split_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] s_in = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] A_out;
  logic [15:0] B_out;
  logic        ovf;
  logic        chk_err;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ovf;
    int          s;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   stall = 1'b0;
  bit   rnd_ready = 1'b0;

  red_split_16bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .out_valid(out_valid), .out_ready(out_ready),
    .A_out(A_out), .B_out(B_out), .ovf(ovf), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: fill lanes a..d greedily, each clamped to a signed byte.
  task automatic model(input int s, output logic [15:0] ea, output logic [15:0] eb,
                       output logic eovf);
    int rem;
    int v;
    logic [7:0] ln[4];
    rem = s;
    for (int i = 0; i < 4; i++) begin
      v = (rem > 127) ? 127 : ((rem < -128) ? -128 : rem);
      ln[i] = v[7:0];
      rem = rem - v;
    end
    ea = {ln[0], ln[1]};
    eb = {ln[2], ln[3]};
    eovf = (s < -512) || (s > 508);
  endtask

  task automatic send_exp(input int s, input logic [15:0] ea, input logic [15:0] eb,
                          input logic eovf);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    s_in = s[15:0];
    e.a = ea; e.b = eb; e.ovf = eovf; e.s = s; e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int s);
    logic [15:0] ea, eb;
    logic eovf;
    model(s, ea, eb, eovf);
    send_exp(s, ea, eb, eovf);
  endtask

  // out_ready driver, offset from the main driver so stall changes take effect cleanly.
  initial begin
    forever begin
      @(posedge clk); #2;
      out_ready = stall ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: latency, stability while stalled, and result comparison on handshake.
  logic        pv = 1'b0;
  logic [15:0] pa, pb;
  logic        povf, pchk;
  initial begin
    exp_t e;
    int sum;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (out_valid && !pv) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            check("latency", cyc, exp_q[0].acc + 4);
          end
        end
        if (out_valid && pv) begin
          check("stable", {A_out, B_out, ovf, chk_err}, {pa, pb, povf, pchk});
          check("in_ready_in_done", in_ready, 0);
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("A_out", A_out, e.a);
          check("B_out", B_out, e.b);
          check("ovf", ovf, e.ovf);
          check("chk_err", chk_err, 0);
          if (!e.ovf) begin
            sum = $signed(A_out[15:8]) + $signed(A_out[7:0])
                + $signed(B_out[15:8]) + $signed(B_out[7:0]);
            check("lane_sum", sum, e.s);
          end
        end
        pv = out_valid && !out_ready;
        pa = A_out; pb = B_out; povf = ovf; pchk = chk_err;
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_A"}, A_out, 0);
    check({tag, "_B"}, B_out, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_chk"}, chk_err, 0);
  endtask

  initial begin
    int s;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases from the test plan.
    send_exp(300,  16'h7F7F, 16'h2E00, 1'b0);
    send_exp(-512, 16'h8080, 16'h8080, 1'b0);
    send_exp(508,  16'h7F7F, 16'h7F7F, 1'b0);
    send_exp(509,  16'h7F7F, 16'h7F7F, 1'b1);
    send_exp(-600, 16'h8080, 16'h8080, 1'b1);
    wait_drain();

    // Stall in DONE; an in_valid pulse and a simultaneous in_valid/out_ready are ignored.
    @(posedge clk); #1;
    stall = 1'b1;
    send_exp(300, 16'h7F7F, 16'h2E00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("stall_valid", out_valid, 1);
    in_valid = 1'b1; s_in = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("stall_in_ready", in_ready, 0);
    stall = 1'b0;
    in_valid = 1'b1; s_in = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    send_exp(5, 16'h0500, 16'h0000, 1'b0);
    wait_drain();

    // Reset mid-SPLIT discards the partial result.
    send_exp(-7, 16'hF900, 16'h0000, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("midrst2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("no_valid_after_rst", out_valid, 0);
    send_exp(-7, 16'hF900, 16'h0000, 1'b0);
    wait_drain();

    // Randomized in-range traffic with random backpressure, plus some out-of-range values.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = $urandom_range(0, 1020);
      s = s - 512;
      if (s > 508) s = 508;
      send_model(s);
    end
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 65535);
      s = s - 32768;
      send_model(s);
    end
    wait_drain();
    rnd_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/red_split_16bit.md
# red_split_16bit

Multi-cycle inverse of the ALU RED reduction. It takes a 16-bit signed reduced sum S and distributes it across four signed byte lanes a, b, c, d, with A = {a,b} and B = {c,d}, so that RED(A,B) = S. It uses one lane per cycle behind valid/ready handshakes. It sits beside the ALU and feeds operand generation for RED round-trip checks and test-vector synthesis.

## Interface
- No parameters; widths are fixed at 16-bit operands and 8-bit lanes.
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  S is valid
- in_ready  output  1  block can accept S
- s_in  input  16  signed reduced sum to split
- out_valid  output  1  A_out/B_out/ovf/chk_err valid
- out_ready  input  1  consumer accepts result
- A_out  output  16  {a,b}
- B_out  output  16  {c,d}
- ovf  output  1  S was outside [-512, 508]; lanes are saturated
- chk_err  output  1  self-check mismatch (see Configuration)

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture rem ← s_in (17-bit signed), clear lanes, lane index ← 0, ovf ← (s_in < -512) | (s_in > 508). Go to SPLIT.
  - SPLIT: each cycle, lane[idx] ← sat8(rem), where sat8 clamps to [-128, 127]. Then rem ← rem − sat8(rem) and idx++.
    - Lane order: a (A[15:8]), b (A[7:0]), c (B[15:8]), d (B[7:0]).
    - After idx=3, go to DONE.
  - DONE: out_valid=1. Outputs are held stable until out_ready, then go to IDLE.
- Arithmetic rules:
  - rem is 17-bit signed, so no internal wrap.
  - For in-range S, rem is 0 after lane d and the split is exact.
  - For out-of-range S, lanes saturate to all 127 or all -128 and ovf=1.
- Greedy fill is deterministic; it is the required encoding, not just any valid one.
- in_valid while not in IDLE is ignored (in_ready=0).
- out_ready while not in DONE is ignored.
- s_in is sampled only at the accept edge.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, A_out=0, B_out=0, ovf=0, chk_err=0, rem=0.
- Latency:
  - Accept edge T; lanes a, b, c, d are written at edges T+1 through T+4.
  - out_valid=1 from edge T+4.
  - Handshake at edge U returns to IDLE at U; in_ready=1 from U.
- Minimum issue interval: 5 cycles (out_ready held high).
- All outputs are registered. No combinational path exists from in_valid/out_ready to in_ready/out_valid.
- rst_n asserted mid-SPLIT or in DONE: immediate return to reset values. The partial result is discarded and never presented.
- Simultaneous in_valid and out_ready in DONE: the input is not accepted that cycle.

## Configuration
- RED_SPLIT_CHECK_EN defined:
  - A red_16bit instance reduces the final {A_out, B_out}.
  - On the DONE entry edge, chk_err is registered as (ovf==0) & (red_result != sign-extended S).
  - chk_err stays valid with out_valid and clears on IDLE.
- Undefined: no red_16bit instance; chk_err is tied to 0.

## Structure
- Shared package red_pkg holds:
  - RED_MIN = -512 and RED_MAX = 508
  - LANE_MIN = -128 and LANE_MAX = 127
  - the state encoding typedef (IDLE, SPLIT, DONE)
- The only sub-module is red_16bit, instantiated only under RED_SPLIT_CHECK_EN.
- sat8 is a local function, not a module.

## Test plan
- S=300 -> A_out=0x7F7F, B_out=0x2E00, ovf=0, out_valid at accept+4, chk_err=0.
- S=-512 -> A_out=0x8080, B_out=0x8080, ovf=0. S=508 -> 0x7F7F / 0x7F7F, ovf=0.
- S=509 and S=-600 -> lanes saturated (0x7F7F/0x7F7F, 0x8080/0x8080), ovf=1, chk_err=0.
- Stall: out_ready low for 10 cycles -> outputs and out_valid stable, in_ready=0, and an in_valid pulse with S=5 is not accepted. After release, the next accept yields 0x0500/0x0000.
- rst_n low two cycles after accepting S=-7 -> all outputs at reset values, no out_valid. A following S=-7 gives A_out=0xF900, B_out=0x0000.
- Random in-range S, 1000 iterations with RED_SPLIT_CHECK_EN -> chk_err never set and sum of lanes equals S.
